// File: rtl/cache_opr_sequencer.sv
// Sequencer that enables NUM_OPR cache operations one after another, either on a
// fixed per-stage cycle budget or on a per-stage completion handshake.
module cache_opr_sequencer #(
  parameter  int NUM_OPR      = 8,
  parameter  int STAGE_CYCLES = 4,
  parameter  int HANDSHAKE    = 0,
  parameter  int VALID_DLY    = 2,
  localparam int CNT_W        = $clog2(STAGE_CYCLES + 1),
  localparam int STG_W        = $clog2(NUM_OPR)
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               valid,
  input  logic               stage_done,
  input  logic               abort,
  output logic               valid_dly,
  output logic               busy,
  output logic [NUM_OPR-1:0] opr_level,
  output logic [NUM_OPR-1:0] opr_pulse,
  output logic [STG_W-1:0]   cur_stage,
  output logic               seq_done,
  output logic               start_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NUM_OPR - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STAGE_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [STG_W-1:0]     stage_q, stage_d;
  logic [NUM_OPR-1:0]   level_q, level_d;
  logic [NUM_OPR-1:0]   level_prev_q;
  logic                 seq_done_q, seq_done_d;
  logic                 start_err_q, start_err_d;
  logic [VALID_DLY-1:0] vpipe_q, vpipe_d;
  logic                 advance;

  // Stage-advance condition: external completion or the end of the fixed budget.
  assign advance = (HANDSHAKE != 0) ? stage_done : (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_d     = stage_q;
    level_d     = level_q;
    seq_done_d  = 1'b0;
    start_err_d = valid & (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (valid && !abort) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          stage_d = '0;
          level_d = NUM_OPR'(1);
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          stage_d = '0;
          level_d = '0;
        end else begin
          if (HANDSHAKE == 0) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (advance) begin
            cnt_d = '0;
            if (stage_q == LAST_STAGE) begin
              state_d    = ST_DONE;
              seq_done_d = 1'b1;
            end else begin
              stage_d = stage_q + STG_W'(1);
              // Levels are thermometer-coded, so a shift-in of one adds the next stage bit.
              level_d = {level_q[NUM_OPR-2:0], 1'b1};
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        stage_d = '0;
        level_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        stage_d = '0;
        level_d = '0;
      end
    endcase
  end

  generate
    if (VALID_DLY == 1) begin : g_vpipe_one
      assign vpipe_d = valid;
    end else begin : g_vpipe_multi
      assign vpipe_d = {vpipe_q[VALID_DLY-2:0], valid};
    end
  endgenerate

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      stage_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      seq_done_q   <= 1'b0;
      start_err_q  <= 1'b0;
      vpipe_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stage_q      <= stage_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      seq_done_q   <= seq_done_d;
      start_err_q  <= start_err_d;
      vpipe_q      <= vpipe_d;
    end
  end

  assign valid_dly = vpipe_q[VALID_DLY-1];
  assign busy      = (state_q != ST_IDLE);
  assign opr_level = level_q;
  assign opr_pulse = level_q & ~level_prev_q;
  assign cur_stage = stage_q;
  assign seq_done  = seq_done_q;
  assign start_err = start_err_q;

endmodule
